nova_memref_unit: RTL



---
 rtl/nova_memref_unit.sv | 331 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/nova_memref_unit.sv
// ---------------------------------------------------------------------------
// nova_memref_unit
//
// Memory-reference sequencer for the Nova datapath. It accepts an effective
// address from the decode/EA logic, follows indirect pointer chains, and then
// performs the final access. Pointer locations in the auto-increment and
// auto-decrement windows are rewritten as they are followed. The final access
// is a load, a store, an ISZ/DSZ read-modify-write, or no access at all
// (address-only resolve for JMP/JSR). A chain longer than MAX_IND pointer
// reads is abandoned and reported as a fault.
//
// Ports:
//   pclk, prst_n        clock, asynchronous active-low reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_op              0 RESOLVE, 1 LOAD, 2 STORE, 3 ISZ, 4 DSZ (5-7 = RESOLVE)
//   req_ea              effective address
//   req_indirect        req_ea names a pointer location
//   req_wdata           store data
//   rsp_valid/ready     response handshake
//   rsp_addr            final address, or the last pointer address on a fault
//   rsp_data            load data / stored data / new ISZ-DSZ value / 0
//   rsp_skip            ISZ/DSZ result was zero
//   rsp_fault           indirection depth exceeded
//   mem_req/we/adr/dout registered memory cycle, held until mem_ack
//   mem_din, mem_ack    read data and cycle completion
// ---------------------------------------------------------------------------
module nova_memref_unit #(
    parameter int AW      = 15,
    parameter int DW      = 16,
    parameter int MAX_IND = 16,
    parameter int AINC_LO = 16,
    parameter int AINC_HI = 23,
    parameter int ADEC_LO = 24,
    parameter int ADEC_HI = 31
) (
    input  logic          pclk,
    input  logic          prst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [AW-1:0] req_ea,
    input  logic          req_indirect,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [AW-1:0] rsp_addr,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_skip,
    output logic          rsp_fault,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_dout,
    input  logic [DW-1:0] mem_din,
    input  logic          mem_ack
);

    localparam int DEPW = $clog2(MAX_IND + 1);
    localparam logic [DEPW-1:0] DEP_MAX = DEPW'(MAX_IND);

    localparam logic [AW-1:0] AINC_LO_A = AW'(AINC_LO);
    localparam logic [AW-1:0] AINC_HI_A = AW'(AINC_HI);
    localparam logic [AW-1:0] ADEC_LO_A = AW'(ADEC_LO);
    localparam logic [AW-1:0] ADEC_HI_A = AW'(ADEC_HI);

    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_ISZ   = 3'd3;
    localparam logic [2:0] OP_DSZ   = 3'd4;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PTR_RD = 3'd1;
    localparam logic [2:0] PTR_WB = 3'd2;
    localparam logic [2:0] ACC_RD = 3'd3;
    localparam logic [2:0] ACC_WR = 3'd4;
    localparam logic [2:0] RMW_RD = 3'd5;
    localparam logic [2:0] RMW_WR = 3'd6;
    localparam logic [2:0] RESP   = 3'd7;

    logic [2:0]      state, state_n;
    logic [2:0]      op_q, op_n;
    logic [DW-1:0]   wdata_q, wdata_n;
    logic [AW-1:0]   ptr_q, ptr_n;
    logic [DW-1:0]   word_q, word_n;
    logic [DEPW-1:0] depth_q, depth_n;

    logic          rsp_valid_n, rsp_skip_n, rsp_fault_n;
    logic [AW-1:0] rsp_addr_n;
    logic [DW-1:0] rsp_data_n;
    logic          mem_req_n, mem_we_n;
    logic [AW-1:0] mem_adr_n;
    logic [DW-1:0] mem_dout_n;

    logic          go;
    logic          is_ainc, is_adec;
    logic [DW-1:0] ptr_word, rmw_word;

    // Dispatch: shared "what next" decision used on acceptance and after
    // every completed pointer step.
    logic            disp;
    logic [AW-1:0]   disp_addr;
    logic            disp_ind;
    logic [DEPW-1:0] disp_depth;
    logic [2:0]      disp_op;
    logic [DW-1:0]   disp_wdata;

    assign req_ready = (state == IDLE);

    // Next-state logic. Each state waits for a completed memory cycle (go),
    // then either moves to its follow-up memory cycle or hands a target
    // address to the common dispatch block at the bottom.
    always_comb begin
        state_n     = state;
        op_n        = op_q;
        wdata_n     = wdata_q;
        ptr_n       = ptr_q;
        word_n      = word_q;
        depth_n     = depth_q;
        rsp_valid_n = rsp_valid;
        rsp_addr_n  = rsp_addr;
        rsp_data_n  = rsp_data;
        rsp_skip_n  = rsp_skip;
        rsp_fault_n = rsp_fault;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_adr_n   = mem_adr;
        mem_dout_n  = mem_dout;

        disp       = 1'b0;
        disp_addr  = ptr_q;
        disp_ind   = 1'b0;
        disp_depth = depth_q;
        disp_op    = op_q;
        disp_wdata = wdata_q;

        // A stray ack with no cycle outstanding must not advance anything.
        go = mem_req & mem_ack;

        is_ainc = (ptr_q >= AINC_LO_A) && (ptr_q <= AINC_HI_A);
        is_adec = (ptr_q >= ADEC_LO_A) && (ptr_q <= ADEC_HI_A);

        if (is_ainc) begin
            ptr_word = mem_din + DW'(1);
        end else if (is_adec) begin
            ptr_word = mem_din - DW'(1);
        end else begin
            ptr_word = mem_din;
        end

        rmw_word = (op_q == OP_DSZ) ? (mem_din - DW'(1)) : (mem_din + DW'(1));

        case (state)
            IDLE: begin
                if (req_valid) begin
                    op_n       = req_op;
                    wdata_n    = req_wdata;
                    depth_n    = '0;
                    disp       = 1'b1;
                    disp_addr  = req_ea;
                    disp_ind   = req_indirect;
                    disp_depth = '0;
                    disp_op    = req_op;
                    disp_wdata = req_wdata;
                end
            end
            PTR_RD: begin
                if (go) begin
                    depth_n = depth_q + 1'b1;
                    if (is_ainc || is_adec) begin
                        // Rewrite the pointer first; the chain continues
                        // from word_q once the write completes.
                        state_n    = PTR_WB;
                        word_n     = ptr_word;
                        mem_we_n   = 1'b1;
                        mem_dout_n = ptr_word;
                    end else begin
                        disp       = 1'b1;
                        disp_addr  = ptr_word[AW-1:0];
                        disp_ind   = ptr_word[DW-1];
                        disp_depth = depth_q + 1'b1;
                    end
                end
            end
            PTR_WB: begin
                if (go) begin
                    disp       = 1'b1;
                    disp_addr  = word_q[AW-1:0];
                    disp_ind   = word_q[DW-1];
                    disp_depth = depth_q;
                end
            end
            ACC_RD: begin
                if (go) begin
                    state_n     = RESP;
                    mem_req_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_addr_n  = mem_adr;
                    rsp_data_n  = mem_din;
                    rsp_skip_n  = 1'b0;
                    rsp_fault_n = 1'b0;
                end
            end
            ACC_WR: begin
                if (go) begin
                    state_n     = RESP;
                    mem_req_n   = 1'b0;
                    mem_we_n    = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_addr_n  = mem_adr;
                    rsp_data_n  = wdata_q;
                    rsp_skip_n  = 1'b0;
                    rsp_fault_n = 1'b0;
                end
            end
            RMW_RD: begin
                if (go) begin
                    state_n    = RMW_WR;
                    word_n     = rmw_word;
                    mem_we_n   = 1'b1;
                    mem_dout_n = rmw_word;
                end
            end
            RMW_WR: begin
                if (go) begin
                    state_n     = RESP;
                    mem_req_n   = 1'b0;
                    mem_we_n    = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_addr_n  = mem_adr;
                    rsp_data_n  = word_q;
                    rsp_skip_n  = (word_q == '0);
                    rsp_fault_n = 1'b0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        if (disp) begin
            mem_req_n = 1'b0;
            mem_we_n  = 1'b0;
            if (disp_ind && (disp_depth >= DEP_MAX)) begin
                // Depth budget spent with the chain still indirect: report
                // the last pointer followed and skip the final access.
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_addr_n  = ptr_q;
                rsp_data_n  = '0;
                rsp_skip_n  = 1'b0;
                rsp_fault_n = 1'b1;
            end else if (disp_ind) begin
                state_n   = PTR_RD;
                ptr_n     = disp_addr;
                mem_req_n = 1'b1;
                mem_adr_n = disp_addr;
            end else begin
                case (disp_op)
                    OP_LOAD: begin
                        state_n   = ACC_RD;
                        mem_req_n = 1'b1;
                        mem_adr_n = disp_addr;
                    end
                    OP_STORE: begin
                        state_n    = ACC_WR;
                        mem_req_n  = 1'b1;
                        mem_we_n   = 1'b1;
                        mem_adr_n  = disp_addr;
                        mem_dout_n = disp_wdata;
                    end
                    OP_ISZ, OP_DSZ: begin
                        state_n   = RMW_RD;
                        mem_req_n = 1'b1;
                        mem_adr_n = disp_addr;
                    end
                    default: begin
                        state_n     = RESP;
                        rsp_valid_n = 1'b1;
                        rsp_addr_n  = disp_addr;
                        rsp_data_n  = '0;
                        rsp_skip_n  = 1'b0;
                        rsp_fault_n = 1'b0;
                    end
                endcase
            end
        end
    end

    // State and output registers. Reset drops any memory cycle in flight,
    // including a pending read-modify-write store.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            wdata_q   <= '0;
            ptr_q     <= '0;
            word_q    <= '0;
            depth_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            rsp_skip  <= 1'b0;
            rsp_fault <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_dout  <= '0;
        end else begin
            state     <= state_n;
            op_q      <= op_n;
            wdata_q   <= wdata_n;
            ptr_q     <= ptr_n;
            word_q    <= word_n;
            depth_q   <= depth_n;
            rsp_valid <= rsp_valid_n;
            rsp_addr  <= rsp_addr_n;
            rsp_data  <= rsp_data_n;
            rsp_skip  <= rsp_skip_n;
            rsp_fault <= rsp_fault_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_adr   <= mem_adr_n;
            mem_dout  <= mem_dout_n;
        end
    end

endmodule
